// File: rtl/twiddle_sequencer.sv
// ============================================================================
// Module      : twiddle_sequencer
// Description : Per-stage twiddle/bypass source for the 32-point radix-2 MDC
//               FFT multiplier. Optional macro TW_SYNC_CHECK_EN adds the
//               registered sync_err misalignment pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module twiddle_sequencer #(
    parameter int WIDTH = 10,
    parameter int STAGE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sync,
    output logic [WIDTH-2:0] tw_re,
    output logic [WIDTH-2:0] tw_im,
    output logic             mul_mode,
`ifdef TW_SYNC_CHECK_EN
    output logic             sync_err,
`endif
    output logic             tw_valid
);

    // Quarter-turn-aware table at scale 128; k=0 never used (bypass).
    function automatic logic [17:0] rom_lookup(input logic [3:0] k);
        logic signed [8:0] re;
        logic signed [8:0] im;
        re = '0;
        im = '0;
        case (k)
            4'd1:    begin re =  9'sd126; im = -9'sd25;  end
            4'd2:    begin re =  9'sd118; im = -9'sd49;  end
            4'd3:    begin re =  9'sd106; im = -9'sd71;  end
            4'd4:    begin re =  9'sd91;  im = -9'sd91;  end
            4'd5:    begin re =  9'sd71;  im = -9'sd106; end
            4'd6:    begin re =  9'sd49;  im = -9'sd118; end
            4'd7:    begin re =  9'sd25;  im = -9'sd126; end
            4'd8:    begin re =  9'sd0;   im = -9'sd128; end
            4'd9:    begin re = -9'sd25;  im = -9'sd126; end
            4'd10:   begin re = -9'sd49;  im = -9'sd118; end
            4'd11:   begin re = -9'sd71;  im = -9'sd106; end
            4'd12:   begin re = -9'sd91;  im = -9'sd91;  end
            4'd13:   begin re = -9'sd106; im = -9'sd71;  end
            4'd14:   begin re = -9'sd118; im = -9'sd49;  end
            4'd15:   begin re = -9'sd126; im = -9'sd25;  end
            default: begin re =  9'sd0;   im =  9'sd0;   end
        endcase
        return {re, im};
    endfunction

    logic [3:0]        r_cnt;
    logic [WIDTH-2:0]  r_tw_re;
    logic [WIDTH-2:0]  r_tw_im;
    logic              r_mul_mode;
    logic              r_tw_valid;

    logic [3:0]        w_idx;
    logic [3:0]        w_e;
    logic              w_bypass;
    logic [17:0]       w_rom;
    logic signed [8:0] w_rom_re;
    logic signed [8:0] w_rom_im;
    logic [WIDTH-2:0]  w_re_scaled;
    logic [WIDTH-2:0]  w_im_scaled;

    assign w_idx    = in_sync ? 4'd0 : r_cnt;
    assign w_e      = w_idx << STAGE;
    assign w_bypass = (w_e == 4'd0);
    assign w_rom    = rom_lookup(w_e);
    assign w_rom_re = w_rom[17:9];
    assign w_rom_im = w_rom[8:0];

    // Table is native at WIDTH=10; other widths shift to scale 2^(WIDTH-3).
    generate
        if (WIDTH >= 10) begin : g_scale_up
            assign w_re_scaled = (WIDTH-1)'(w_rom_re) <<< (WIDTH-10);
            assign w_im_scaled = (WIDTH-1)'(w_rom_im) <<< (WIDTH-10);
        end else begin : g_scale_down
            logic signed [8:0] w_re_sh;
            logic signed [8:0] w_im_sh;
            assign w_re_sh     = w_rom_re >>> (10-WIDTH);
            assign w_im_sh     = w_rom_im >>> (10-WIDTH);
            assign w_re_scaled = w_re_sh[WIDTH-2:0];
            assign w_im_scaled = w_im_sh[WIDTH-2:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= 4'd0;
            r_tw_re    <= '0;
            r_tw_im    <= '0;
            r_mul_mode <= 1'b1;
            r_tw_valid <= 1'b0;
        end else begin
            r_tw_valid <= in_valid;
            if (in_valid) begin
                r_cnt      <= w_idx + 4'd1;
                r_mul_mode <= w_bypass;
                r_tw_re    <= w_bypass ? '0 : w_re_scaled;
                r_tw_im    <= w_bypass ? '0 : w_im_scaled;
            end
        end
    end

`ifdef TW_SYNC_CHECK_EN
    logic r_sync_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= in_valid & in_sync & (r_cnt != 4'd0);
        end
    end

    assign sync_err = r_sync_err;
`endif

    assign tw_re    = r_tw_re;
    assign tw_im    = r_tw_im;
    assign mul_mode = r_mul_mode;
    assign tw_valid = r_tw_valid;

endmodule

`default_nettype wire

// File: tb/tb_twiddle_sequencer.sv
// ============================================================================
// Module      : tb_twiddle_sequencer
// Description : Randomized self-checking bench for twiddle_sequencer at
//               STAGE 0, 1 and 4 against a trigonometric reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_twiddle_sequencer;

    localparam int WIDTH = 10;
    localparam int c_stage[3] = '{0, 1, 4};

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_sync;
    logic [WIDTH-2:0] tw_re [3];
    logic [WIDTH-2:0] tw_im [3];
    logic             mul_mode [3];
    logic             tw_valid [3];
`ifdef TW_SYNC_CHECK_EN
    logic             sync_err [3];
`endif

    always #5 clk = ~clk;

    twiddle_sequencer #(.WIDTH(WIDTH), .STAGE(0)) u_dut_s0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync),
        .tw_re(tw_re[0]), .tw_im(tw_im[0]), .mul_mode(mul_mode[0]),
`ifdef TW_SYNC_CHECK_EN
        .sync_err(sync_err[0]),
`endif
        .tw_valid(tw_valid[0])
    );

    twiddle_sequencer #(.WIDTH(WIDTH), .STAGE(1)) u_dut_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync),
        .tw_re(tw_re[1]), .tw_im(tw_im[1]), .mul_mode(mul_mode[1]),
`ifdef TW_SYNC_CHECK_EN
        .sync_err(sync_err[1]),
`endif
        .tw_valid(tw_valid[1])
    );

    twiddle_sequencer #(.WIDTH(WIDTH), .STAGE(4)) u_dut_s4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync),
        .tw_re(tw_re[2]), .tw_im(tw_im[2]), .mul_mode(mul_mode[2]),
`ifdef TW_SYNC_CHECK_EN
        .sync_err(sync_err[2]),
`endif
        .tw_valid(tw_valid[2])
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: frame position plus expected output registers.
    int m_cnt;
    int rom_re [16];
    int rom_im [16];
    int exp_re [3];
    int exp_im [3];
    int exp_mode [3];
    int exp_valid;
    int exp_serr;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    task automatic model_reset();
        m_cnt     = 0;
        exp_valid = 0;
        exp_serr  = 0;
        for (int i = 0; i < 3; i++) begin
            exp_re[i]   = 0;
            exp_im[i]   = 0;
            exp_mode[i] = 1;
        end
    endtask

    task automatic compare_all(input string where);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s s%0d tw_valid", where, c_stage[i]), int'(tw_valid[i]), exp_valid);
            check($sformatf("%s s%0d mul_mode", where, c_stage[i]), int'(mul_mode[i]), exp_mode[i]);
            check($sformatf("%s s%0d tw_re", where, c_stage[i]), int'($signed(tw_re[i])), exp_re[i]);
            check($sformatf("%s s%0d tw_im", where, c_stage[i]), int'($signed(tw_im[i])), exp_im[i]);
`ifdef TW_SYNC_CHECK_EN
            check($sformatf("%s s%0d sync_err", where, c_stage[i]), int'(sync_err[i]), exp_serr);
`endif
        end
    endtask

    task automatic step(input logic v, input logic s, input string where);
        int idx;
        int e;
        @(negedge clk);
        in_valid = v;
        in_sync  = s;
        @(posedge clk);
        #1;
        if (v) begin
            idx       = s ? 0 : m_cnt;
            exp_serr  = (s && m_cnt != 0) ? 1 : 0;
            exp_valid = 1;
            for (int i = 0; i < 3; i++) begin
                e = (idx * (1 << c_stage[i])) % 16;
                exp_mode[i] = (e == 0) ? 1 : 0;
                exp_re[i]   = (e == 0) ? 0 : rom_re[e];
                exp_im[i]   = (e == 0) ? 0 : rom_im[e];
            end
            m_cnt = (idx + 1) % 16;
        end else begin
            exp_valid = 0;
            exp_serr  = 0;
        end
        compare_all(where);
    endtask

    // Asynchronous reset asserted away from any clock edge.
    task automatic async_reset(input string where);
        @(negedge clk);
        in_valid = 1'b0;
        in_sync  = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all(where);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        real ang;
        for (int k = 0; k < 16; k++) begin
            ang       = 2.0 * 3.14159265358979 * k / 32.0;
            rom_re[k] = $rtoi($floor(128.0 * $cos(ang) + 0.5));
            rom_im[k] = -$rtoi($floor(128.0 * $sin(ang) + 0.5));
        end

        rst      = 1'b1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("por");
        rst = 1'b0;

        // One full frame with sync on the first sample.
        for (int k = 0; k < 16; k++) begin
            step(1'b1, k == 0, "frame");
            if (k == 1) begin
                check("s0 idx1 re", int'($signed(tw_re[0])), 126);
                check("s0 idx1 im", int'($signed(tw_im[0])), -25);
            end
            if (k == 3) check("s1 idx3 re", int'($signed(tw_re[1])), 49);
            if (k == 8) begin
                check("s0 idx8 im", int'($signed(tw_im[0])), -128);
                check("s1 idx8 bypass", int'(mul_mode[1]), 1);
            end
            if (k == 9) check("s1 idx9 re", int'($signed(tw_re[1])), 118);
            if (k == 15) check("s0 idx15 re", int'($signed(tw_re[0])), -126);
        end

        // Second frame with no sync relies on the 15 -> 0 wrap.
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'b0, "wrap");
            check("s4 always bypass", int'(mul_mode[2]), 1);
        end

        // Gapped valids: outputs hold and in_sync is ignored during gaps.
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, "gap valid");
            repeat (3) step(1'b0, 1'($urandom_range(0, 1)), "gap idle");
        end

        // Mid-frame sync at cnt=5.
        async_reset("rst mid");
        for (int k = 0; k < 5; k++) step(1'b1, k == 0, "pre sync");
        step(1'b1, 1'b1, "late sync");
        check("late sync bypass", int'(mul_mode[0]), 1);
        step(1'b1, 1'b0, "after sync");
        check("after sync re", int'($signed(tw_re[0])), 126);

        // Randomized stream with one asynchronous reset mid-run.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) async_reset("rand rst");
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 11) == 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
